// File: rtl/adc_model_pkg.sv
// Shared types and constants for the multi-channel SPI A2D behavioural model.
//   FRAME_W  : SPI frame length in SCLK periods
//   ADDR_LSB : lowest bit of the channel address field inside the command word
//   ADDR_W   : width of the channel address field
//   CNT_W    : width of the SCLK-rise counter (must hold 0..FRAME_W)
//   adc_state_e : frame sequencing states
package adc_model_pkg;

  localparam int unsigned FRAME_W  = 16;
  localparam int unsigned ADDR_LSB = 11;
  localparam int unsigned ADDR_W   = 3;
  localparam int unsigned CNT_W    = 5;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StShift,
    StDone
  } adc_state_e;

endpackage

// File: rtl/adc_spi_shift.sv
// SPI mode-0 slave datapath: input synchronisers, edge detection, 16-bit tx/rx shift
// registers and SCLK-rise counter. Framing decisions are left to the parent.
//   clk_i, rst_i     : system clock, synchronous active-high reset
//   ss_n_i, sclk_i, mosi_i : raw SPI inputs (asynchronous to clk_i)
//   load_i, resp_i   : load resp_i into the tx register and clear the bit counter
//   miso_o           : serial data out, forced low while slave select is high
//   frame_start_o    : slave select fell
//   frame_done_o     : slave select rose after exactly FRAME_W SCLK rises
//   frame_short_o    : slave select rose after fewer SCLK rises
//   cmd_o            : bits received this frame
module adc_spi_shift
  import adc_model_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               ss_n_i,
  input  logic               sclk_i,
  input  logic               mosi_i,
  input  logic               load_i,
  input  logic [FRAME_W-1:0] resp_i,
  output logic               miso_o,
  output logic               frame_start_o,
  output logic               frame_done_o,
  output logic               frame_short_o,
  output logic [FRAME_W-1:0] cmd_o
);

  // [1] is the synchronised value, [2] its previous sample for edge detection.
  logic [2:0]         sclk_q, sclk_d;
  logic [2:0]         ss_q, ss_d;
  // MOSI goes through the same two flops so it lines up with the synced SCLK.
  logic [1:0]         mosi_q, mosi_d;
  logic [FRAME_W-1:0] tx_q, tx_d;
  logic [FRAME_W-1:0] rx_q, rx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic ss_active;
  logic sclk_rise;
  logic sclk_fall;
  logic ss_rise;
  logic cnt_full;

  assign ss_active = ~ss_q[1];
  assign sclk_rise = sclk_q[1] & ~sclk_q[2] & ss_active;
  assign sclk_fall = ~sclk_q[1] & sclk_q[2] & ss_active;
  assign ss_rise   = ss_q[1] & ~ss_q[2];
  assign cnt_full  = (cnt_q == CNT_W'(FRAME_W));

  assign frame_start_o = ss_q[2] & ~ss_q[1];
  assign frame_done_o  = ss_rise & cnt_full;
  assign frame_short_o = ss_rise & ~cnt_full;
  assign cmd_o         = rx_q;
  assign miso_o        = ss_active & tx_q[FRAME_W-1];

  always_comb begin
    sclk_d = {sclk_q[1:0], sclk_i};
    ss_d   = {ss_q[1:0], ss_n_i};
    mosi_d = {mosi_q[0], mosi_i};
    tx_d   = tx_q;
    rx_d   = rx_q;
    cnt_d  = cnt_q;
    if (load_i) begin
      tx_d  = resp_i;
      cnt_d = '0;
    end else begin
      if (sclk_rise) begin
        rx_d = {rx_q[FRAME_W-2:0], mosi_q[1]};
        if (!cnt_full) cnt_d = cnt_q + CNT_W'(1);
      end
      if (sclk_fall) tx_d = {tx_q[FRAME_W-2:0], 1'b0};
    end
  end

  // Slave-select sync flops clear to 0 so that a reset taken mid-frame (SS_n still
  // low) does not manufacture a fresh SS_n fall; the trailing SS_n rise then lands
  // in idle and is ignored.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sclk_q <= '0;
      ss_q   <= '0;
      mosi_q <= '0;
      tx_q   <= '0;
      rx_q   <= '0;
      cnt_q  <= '0;
    end else begin
      sclk_q <= sclk_d;
      ss_q   <= ss_d;
      mosi_q <= mosi_d;
      tx_q   <= tx_d;
      rx_q   <= rx_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/adc_multi_ch_model.sv
// Behavioural model of a 16-bit-frame SPI A2D with NUM_CH independently ramping
// channels. Each completed frame returns the channel addressed by the previous frame,
// then decrements that channel by STEP (saturating or wrapping).
//   clk_i, rst_i     : system clock, synchronous active-high reset
//   ss_n_i, sclk_i, mosi_i, miso_o : SPI slave pins (mode 0, MSB first)
//   ld_en_i, ld_ch_i, ld_val_i     : backdoor channel load, wins over a same-cycle step
//   ch_err_o         : one-clock pulse, completed frame addressed channel >= NUM_CH
//   frm_err_o        : one-clock pulse, frame ended before FRAME_W SCLK rises
//   conv_cnt_o       : completed-frame count, wraps
module adc_multi_ch_model
  import adc_model_pkg::*;
#(
  parameter int unsigned NUM_CH   = 8,
  parameter int unsigned DATA_W   = 12,
  parameter logic [15:0] INIT_VAL = 16'hC00,
  parameter logic [15:0] STEP     = 16'h010,
  parameter bit          WRAP     = 1'b0,
  parameter bit          TAG_CH   = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              ss_n_i,
  input  logic              sclk_i,
  input  logic              mosi_i,
  output logic              miso_o,
  input  logic              ld_en_i,
  input  logic [2:0]        ld_ch_i,
  input  logic [DATA_W-1:0] ld_val_i,
  output logic              ch_err_o,
  output logic              frm_err_o,
  output logic [15:0]       conv_cnt_o
);

  adc_state_e         state_q, state_d;
  logic [ADDR_W-1:0]  ptr_q, ptr_d;
  logic [DATA_W-1:0]  ch_q [NUM_CH];
  logic [DATA_W-1:0]  ch_d [NUM_CH];
  logic [15:0]        cnt_q, cnt_d;
  logic               ch_err_q, ch_err_d;
  logic               frm_err_q, frm_err_d;

  logic               load;
  logic               frame_start;
  logic               frame_done;
  logic               frame_short;
  logic [FRAME_W-1:0] cmd;
  logic [FRAME_W-1:0] resp;
  logic [ADDR_W-1:0]  addr;
  logic [DATA_W-1:0]  cur_val;
  logic [DATA_W-1:0]  step_val;
  logic [31:0]        cur_wide;
  logic               unused_cmd;

  adc_spi_shift u_shift (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .ss_n_i        (ss_n_i),
    .sclk_i        (sclk_i),
    .mosi_i        (mosi_i),
    .load_i        (load),
    .resp_i        (resp),
    .miso_o        (miso_o),
    .frame_start_o (frame_start),
    .frame_done_o  (frame_done),
    .frame_short_o (frame_short),
    .cmd_o         (cmd)
  );

  assign addr       = cmd[ADDR_LSB +: ADDR_W];
  assign unused_cmd = ^{cmd[FRAME_W-1:ADDR_LSB+ADDR_W], cmd[ADDR_LSB-1:0]};

  // Value of the channel the pointer selects (the one returned this frame).
  always_comb begin
    cur_val = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (ptr_q == ADDR_W'(i)) cur_val = ch_q[i];
    end
  end

  always_comb begin
    cur_wide = 32'(cur_val);
    if (WRAP) begin
      step_val = DATA_W'(cur_wide - 32'(STEP));
    end else if (cur_wide < 32'(STEP)) begin
      step_val = '0;
    end else begin
      step_val = DATA_W'(cur_wide - 32'(STEP));
    end
  end

  assign resp = 16'(cur_val) | (TAG_CH ? 16'(ptr_q) : 16'h0000);

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    ch_d      = ch_q;
    ch_err_d  = 1'b0;
    frm_err_d = 1'b0;
    load      = 1'b0;

    case (state_q)
      StIdle: begin
        if (frame_start) state_d = StLoad;
      end
      StLoad: begin
        load    = 1'b1;
        state_d = StShift;
      end
      StShift: begin
        if (frame_done) begin
          state_d = StDone;
        end else if (frame_short) begin
          frm_err_d = 1'b1;
          state_d   = StIdle;
        end
      end
      StDone: begin
        for (int unsigned i = 0; i < NUM_CH; i++) begin
          if (ptr_q == ADDR_W'(i)) ch_d[i] = step_val;
        end
        if (32'(addr) < NUM_CH) begin
          ptr_d = addr;
        end else begin
          ch_err_d = 1'b1;
        end
        cnt_d   = cnt_q + 16'd1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Applied after the step so a coincident backdoor load overrides it.
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (ld_en_i && (ld_ch_i == ADDR_W'(i))) ch_d[i] = ld_val_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      ptr_q     <= '0;
      cnt_q     <= '0;
      ch_err_q  <= 1'b0;
      frm_err_q <= 1'b0;
      for (int unsigned i = 0; i < NUM_CH; i++) ch_q[i] <= DATA_W'(INIT_VAL);
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      ch_err_q  <= ch_err_d;
      frm_err_q <= frm_err_d;
      ch_q      <= ch_d;
    end
  end

  assign ch_err_o   = ch_err_q;
  assign frm_err_o  = frm_err_q;
  assign conv_cnt_o = cnt_q;

endmodule

// File: tb/tb_adc_multi_ch_model.sv
// Bench for adc_multi_ch_model. Two instances share one SPI bus: instance 0 uses the
// defaults (8 channels, saturating), instance 1 has 4 channels and wraps. A plain
// array model of channel values, pointer and frame count predicts every response.
module tb_adc_multi_ch_model;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ss_n = 1'b1;
  logic        sclk = 1'b0;
  logic        mosi = 1'b0;
  logic        ld_en = 1'b0;
  logic [2:0]  ld_ch = 3'd0;
  logic [11:0] ld_val = 12'd0;
  logic        miso_a, miso_b, ch_err_a, ch_err_b, frm_err_a, frm_err_b;
  logic [15:0] conv_a, conv_b;

  always #5 clk = ~clk;

  adc_multi_ch_model u_dut_a (
    .clk_i (clk), .rst_i (rst), .ss_n_i (ss_n), .sclk_i (sclk), .mosi_i (mosi),
    .miso_o (miso_a), .ld_en_i (ld_en), .ld_ch_i (ld_ch), .ld_val_i (ld_val),
    .ch_err_o (ch_err_a), .frm_err_o (frm_err_a), .conv_cnt_o (conv_a)
  );

  adc_multi_ch_model #(.NUM_CH(4), .WRAP(1'b1)) u_dut_b (
    .clk_i (clk), .rst_i (rst), .ss_n_i (ss_n), .sclk_i (sclk), .mosi_i (mosi),
    .miso_o (miso_b), .ld_en_i (ld_en), .ld_ch_i (ld_ch), .ld_val_i (ld_val),
    .ch_err_o (ch_err_b), .frm_err_o (frm_err_b), .conv_cnt_o (conv_b)
  );

  // Free-running pulse counters; tests compare before/after deltas.
  int n_che[2] = '{0, 0};
  int n_fre[2] = '{0, 0};
  always @(posedge clk) begin
    if (ch_err_a)  n_che[0] <= n_che[0] + 1;
    if (ch_err_b)  n_che[1] <= n_che[1] + 1;
    if (frm_err_a) n_fre[0] <= n_fre[0] + 1;
    if (frm_err_b) n_fre[1] <= n_fre[1] + 1;
  end

  int passed = 0;
  int total  = 0;

  // ---------------- reference model ----------------
  int mval[2][8];
  int mptr[2];
  int mcnt[2];
  int nch[2]   = '{8, 4};
  bit mwrap[2] = '{1'b0, 1'b1};
  int exp_resp[2];
  int exp_che[2];

  function automatic int step_of(int v, bit w);
    if (w) return (v - 16) & 'hFFF;
    return (v < 16) ? 0 : v - 16;
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int c = 0; c < 8; c++) mval[k][c] = 'hC00;
      mptr[k] = 0;
      mcnt[k] = 0;
    end
  endfunction

  function automatic void model_load(int ch, int v);
    for (int k = 0; k < 2; k++) if (ch < nch[k]) mval[k][ch] = v;
  endfunction

  function automatic void model_frame(logic [15:0] cmd, bit hold, int lch, int lval);
    int addr;
    addr = int'(cmd[13:11]);
    for (int k = 0; k < 2; k++) begin
      exp_resp[k] = mval[k][mptr[k]] | mptr[k];
      mval[k][mptr[k]] = step_of(mval[k][mptr[k]], mwrap[k]);
      if (hold && lch < nch[k]) mval[k][lch] = lval;
      if (addr < nch[k]) begin
        mptr[k]    = addr;
        exp_che[k] = 0;
      end else begin
        exp_che[k] = 1;
      end
      mcnt[k] = (mcnt[k] + 1) % 65536;
    end
  endfunction

  // ---------------- bus driver ----------------
  logic [15:0] rx[2];
  logic        rst_miso;

  task automatic xfer(input logic [15:0] cmd, input int nbits, input int rst_at,
                      input bit hold);
    rx[0] = '0;
    rx[1] = '0;
    rst_miso = 1'b0;
    @(negedge clk) ss_n = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      if (i == rst_at) begin
        rst = 1'b1;
        @(negedge clk);
        rst_miso = miso_a | miso_b;
        repeat (2) @(negedge clk);
        rst = 1'b0;
      end
      repeat (2) @(negedge clk);
      mosi = cmd[15-i];
      repeat (6) @(negedge clk);
      rx[0] = {rx[0][14:0], miso_a};
      rx[1] = {rx[1][14:0], miso_b};
      sclk = 1'b1;
      repeat (8) @(negedge clk);
      sclk = 1'b0;
    end
    repeat (4) @(negedge clk);
    if (hold) ld_en = 1'b1;
    ss_n = 1'b1;
    repeat (10) @(negedge clk);
    ld_en = 1'b0;
    mosi  = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; ss_n = 1'b1; sclk = 1'b0; ld_en = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    model_reset();
  endtask

  task automatic do_load(input int ch, input int v);
    @(negedge clk);
    ld_ch = 3'(ch); ld_val = 12'(v); ld_en = 1'b1;
    @(negedge clk);
    ld_en = 1'b0;
    model_load(ch, v);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int c_fre[2];
    do_reset();
    c_fre = n_fre;
    repeat (5) @(negedge clk);
    total++; if (conv_a !== 16'h0) $display("FAIL reset_conv_a got %h want 0000", conv_a); else passed++;
    total++; if (conv_b !== 16'h0) $display("FAIL reset_conv_b got %h want 0000", conv_b); else passed++;
    total++; if ({miso_a, miso_b} !== 2'b00) $display("FAIL reset_miso got %b want 00", {miso_a, miso_b}); else passed++;
    total++; if ({ch_err_a, ch_err_b, frm_err_a, frm_err_b} !== 4'b0)
      $display("FAIL reset_errs got %b want 0000", {ch_err_a, ch_err_b, frm_err_a, frm_err_b}); else passed++;
    total++; if (n_fre[0] != c_fre[0]) $display("FAIL reset_frm_pulse got %0d want 0", n_fre[0] - c_fre[0]); else passed++;
  endtask

  task automatic test_basic();
    logic [15:0] want_a[2] = '{16'hC00, 16'hC04};
    do_reset();
    for (int f = 0; f < 2; f++) begin
      xfer(16'(4 << 11), 16, -1, 1'b0);
      model_frame(16'(4 << 11), 1'b0, 0, 0);
      total++; if (rx[0] !== want_a[f]) $display("FAIL basic_resp_a%0d got %h want %h", f, rx[0], want_a[f]); else passed++;
      total++; if (rx[1] !== 16'(exp_resp[1])) $display("FAIL basic_resp_b%0d got %h want %h", f, rx[1], 16'(exp_resp[1])); else passed++;
    end
    total++; if (conv_a !== 16'd2) $display("FAIL basic_conv got %0d want 2", conv_a); else passed++;
  endtask

  task automatic test_repeat();
    logic [15:0] want_a[3] = '{16'hC00, 16'hC05, 16'hBF5};
    do_reset();
    for (int f = 0; f < 3; f++) begin
      xfer(16'(5 << 11) | 16'h07FF, 16, -1, 1'b0);
      model_frame(16'(5 << 11), 1'b0, 0, 0);
      total++; if (rx[0] !== want_a[f]) $display("FAIL repeat_resp_a%0d got %h want %h", f, rx[0], want_a[f]); else passed++;
      total++; if (rx[1] !== 16'(exp_resp[1])) $display("FAIL repeat_resp_b%0d got %h want %h", f, rx[1], 16'(exp_resp[1])); else passed++;
    end
    total++; if (conv_a !== 16'd3) $display("FAIL repeat_conv_a got %0d want 3", conv_a); else passed++;
    total++; if (conv_b !== 16'd3) $display("FAIL repeat_conv_b got %0d want 3", conv_b); else passed++;
  endtask

  task automatic test_load_sat();
    logic [15:0] want_a[3] = '{16'hC00, 16'h00A, 16'h002};
    logic [15:0] want_b[3] = '{16'hC00, 16'h00A, 16'hFFA};
    do_reset();
    do_load(2, 'h008);
    for (int f = 0; f < 3; f++) begin
      xfer(16'(2 << 11), 16, -1, 1'b0);
      model_frame(16'(2 << 11), 1'b0, 0, 0);
      total++; if (rx[0] !== want_a[f]) $display("FAIL sat_resp_a%0d got %h want %h", f, rx[0], want_a[f]); else passed++;
      total++; if (rx[1] !== want_b[f]) $display("FAIL wrap_resp_b%0d got %h want %h", f, rx[1], want_b[f]); else passed++;
    end
  endtask

  task automatic test_bad_ch();
    int c_che[2];
    c_che = n_che;
    xfer(16'(6 << 11), 16, -1, 1'b0);
    model_frame(16'(6 << 11), 1'b0, 0, 0);
    for (int k = 0; k < 2; k++) begin
      total++; if (n_che[k] - c_che[k] != exp_che[k])
        $display("FAIL badch_pulse%0d got %0d want %0d", k, n_che[k] - c_che[k], exp_che[k]); else passed++;
      total++; if (rx[k] !== 16'(exp_resp[k])) $display("FAIL badch_resp%0d got %h want %h", k, rx[k], 16'(exp_resp[k])); else passed++;
    end
    total++; if (conv_b !== 16'(mcnt[1])) $display("FAIL badch_conv_b got %0d want %0d", conv_b, mcnt[1]); else passed++;
    xfer(16'(1 << 11), 16, -1, 1'b0);
    model_frame(16'(1 << 11), 1'b0, 0, 0);
    for (int k = 0; k < 2; k++) begin
      total++; if (rx[k] !== 16'(exp_resp[k])) $display("FAIL badch_next%0d got %h want %h", k, rx[k], 16'(exp_resp[k])); else passed++;
    end
  endtask

  task automatic test_short_frame();
    int c_fre[2];
    int c_che[2];
    c_fre = n_fre;
    c_che = n_che;
    xfer(16'(3 << 11), 9, -1, 1'b0);
    for (int k = 0; k < 2; k++) begin
      total++; if (n_fre[k] - c_fre[k] != 1) $display("FAIL short_pulse%0d got %0d want 1", k, n_fre[k] - c_fre[k]); else passed++;
      total++; if (n_che[k] != c_che[k]) $display("FAIL short_cherr%0d got %0d want 0", k, n_che[k] - c_che[k]); else passed++;
    end
    total++; if (conv_a !== 16'(mcnt[0])) $display("FAIL short_conv got %0d want %0d", conv_a, mcnt[0]); else passed++;
    xfer(16'(0 << 11), 16, -1, 1'b0);
    model_frame(16'(0 << 11), 1'b0, 0, 0);
    for (int k = 0; k < 2; k++) begin
      total++; if (rx[k] !== 16'(exp_resp[k])) $display("FAIL short_next%0d got %h want %h", k, rx[k], 16'(exp_resp[k])); else passed++;
    end
  endtask

  task automatic test_load_wins();
    int lch;
    int lval;
    logic [15:0] cmd;
    lch  = mptr[0];
    lval = int'($urandom_range(32, 4095));
    cmd  = 16'(lch << 11);
    ld_ch  = 3'(lch);
    ld_val = 12'(lval);
    xfer(cmd, 16, -1, 1'b1);
    model_frame(cmd, 1'b1, lch, lval);
    xfer(cmd, 16, -1, 1'b0);
    model_frame(cmd, 1'b0, 0, 0);
    total++; if (rx[0] !== 16'(lval | lch)) $display("FAIL load_wins_a got %h want %h", rx[0], 16'(lval | lch)); else passed++;
    total++; if (rx[1] !== 16'(exp_resp[1])) $display("FAIL load_wins_b got %h want %h", rx[1], 16'(exp_resp[1])); else passed++;
  endtask

  task automatic test_mid_reset();
    int c_fre[2];
    xfer(16'(3 << 11), 16, -1, 1'b0);
    model_frame(16'(3 << 11), 1'b0, 0, 0);
    c_fre = n_fre;
    xfer(16'(7 << 11), 16, 8, 1'b0);
    model_reset();
    total++; if (rst_miso !== 1'b0) $display("FAIL midrst_miso got %b want 0", rst_miso); else passed++;
    total++; if (n_fre[0] != c_fre[0]) $display("FAIL midrst_frm got %0d want 0", n_fre[0] - c_fre[0]); else passed++;
    total++; if (conv_a !== 16'h0) $display("FAIL midrst_conv got %h want 0000", conv_a); else passed++;
    xfer(16'(1 << 11), 16, -1, 1'b0);
    model_frame(16'(1 << 11), 1'b0, 0, 0);
    total++; if (rx[0] !== 16'hC00) $display("FAIL midrst_next_a got %h want 0c00", rx[0]); else passed++;
    total++; if (rx[1] !== 16'hC00) $display("FAIL midrst_next_b got %h want 0c00", rx[1]); else passed++;
  endtask

  task automatic test_random();
    int c_che[2];
    int c_fre[2];
    int r;
    int lch;
    int lval;
    bit hold;
    logic [15:0] cmd;
    for (int it = 0; it < 24; it++) begin
      r = int'($urandom_range(0, 9));
      c_che = n_che;
      c_fre = n_fre;
      if (r == 0) begin
        do_load(int'($urandom_range(0, 7)), int'($urandom_range(0, 4095)));
      end else if (r == 1) begin
        xfer(16'($urandom), int'($urandom_range(1, 15)), -1, 1'b0);
        for (int k = 0; k < 2; k++) begin
          total++; if (n_fre[k] - c_fre[k] != 1) $display("FAIL rnd_short%0d it%0d got %0d want 1", k, it, n_fre[k] - c_fre[k]); else passed++;
        end
        total++; if (conv_b !== 16'(mcnt[1])) $display("FAIL rnd_short_conv it%0d got %0d want %0d", it, conv_b, mcnt[1]); else passed++;
      end else begin
        cmd  = 16'($urandom);
        hold = ($urandom_range(0, 3) == 0);
        lch  = int'($urandom_range(0, 7));
        lval = int'($urandom_range(0, 4095));
        ld_ch  = 3'(lch);
        ld_val = 12'(lval);
        xfer(cmd, 16, -1, hold);
        model_frame(cmd, hold, lch, lval);
        for (int k = 0; k < 2; k++) begin
          total++; if (rx[k] !== 16'(exp_resp[k])) $display("FAIL rnd_resp%0d it%0d got %h want %h", k, it, rx[k], 16'(exp_resp[k])); else passed++;
          total++; if (n_che[k] - c_che[k] != exp_che[k])
            $display("FAIL rnd_cherr%0d it%0d got %0d want %0d", k, it, n_che[k] - c_che[k], exp_che[k]); else passed++;
        end
        total++; if (conv_a !== 16'(mcnt[0])) $display("FAIL rnd_conv it%0d got %0d want %0d", it, conv_a, mcnt[0]); else passed++;
      end
    end
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_repeat();
    test_load_sat();
    test_bad_ch();
    test_short_frame();
    test_load_wins();
    test_mid_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
